// File: rtl/bsg_cache_wormhole_to_dma_mem_if.sv
// Memory-side DMA port of the cache wormhole responder: one command channel,
// a write-data stream toward memory and a read-data stream back from memory.
`timescale 1ns/1ps
interface bsg_cache_wormhole_to_dma_mem_if #(
    parameter int addr_width_p = 32,
    parameter int mask_width_p = 8,
    parameter int data_width_p = 32
) ();
    logic                    mem_cmd_v_o;
    logic                    mem_cmd_write_not_read_o;
    logic [addr_width_p-1:0] mem_cmd_addr_o;
    logic [mask_width_p-1:0] mem_cmd_mask_o;
    logic                    mem_cmd_ready_and_i;

    logic [data_width_p-1:0] mem_wdata_o;
    logic                    mem_wdata_v_o;
    logic                    mem_wdata_ready_and_i;

    logic [data_width_p-1:0] mem_rdata_i;
    logic                    mem_rdata_v_i;
    logic                    mem_rdata_ready_and_o;

    // master: the responder issuing commands; slave: the memory controller
    modport master (
        output mem_cmd_v_o, mem_cmd_write_not_read_o, mem_cmd_addr_o, mem_cmd_mask_o,
        input  mem_cmd_ready_and_i,
        output mem_wdata_o, mem_wdata_v_o,
        input  mem_wdata_ready_and_i,
        input  mem_rdata_i, mem_rdata_v_i,
        output mem_rdata_ready_and_o
    );

    modport slave (
        input  mem_cmd_v_o, mem_cmd_write_not_read_o, mem_cmd_addr_o, mem_cmd_mask_o,
        output mem_cmd_ready_and_i,
        input  mem_wdata_o, mem_wdata_v_o,
        output mem_wdata_ready_and_i,
        output mem_rdata_i, mem_rdata_v_i,
        input  mem_rdata_ready_and_o
    );
endinterface

// File: rtl/bsg_cache_wormhole_to_dma_mem.sv
// Terminates cache DMA wormhole packets (hdr/addr/[mask]/data) and turns each
// into one memory command; reads return a header flit plus the read beats.
`timescale 1ns/1ps
module bsg_cache_wormhole_to_dma_mem #(
    parameter int dma_addr_width_p = 28,
    parameter int dma_burst_len_p  = 4,
    parameter int dma_mask_width_p = 8,
    parameter int wh_flit_width_p  = 32,
    parameter int wh_cord_width_p  = 4,
    parameter int wh_len_width_p   = 4,
    parameter int wh_cid_width_p   = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [wh_flit_width_p+1:0] wh_link_sif_i,
    output logic [wh_flit_width_p+1:0] wh_link_sif_o,
    input  logic [wh_cord_width_p-1:0] my_wh_cord_i,
    input  logic [wh_cid_width_p-1:0]  my_wh_cid_i,
    bsg_cache_wormhole_to_dma_mem_if.master mem
);
    localparam int W          = wh_flit_width_p;
    localparam int CW         = (dma_burst_len_p > 1) ? $clog2(dma_burst_len_p) : 1;
    localparam int CORD_LSB   = 0;
    localparam int LEN_LSB    = CORD_LSB + wh_cord_width_p;
    localparam int CID_LSB    = LEN_LSB + wh_len_width_p;
    localparam int SCORD_LSB  = CID_LSB + wh_cid_width_p;
    localparam int SCID_LSB   = SCORD_LSB + wh_cord_width_p;
    localparam int OP_LSB     = SCID_LSB + wh_cid_width_p;
    localparam logic [CW-1:0] LAST_BEAT = CW'(dma_burst_len_p - 1);

    typedef enum logic [2:0] {
        S_RECV_HDR, S_RECV_ADDR, S_RECV_MASK, S_CMD, S_WDATA, S_RESP_HDR, S_RESP_DATA
    } state_e;

    state_e                      r_state, w_state_n;
    logic [W-1:0]                r_hdr;
    logic [dma_addr_width_p-1:0] r_addr;
    logic [dma_mask_width_p-1:0] r_mask;
    logic [CW-1:0]               r_cnt;

    logic         w_in_v, w_out_rdy;
    logic [W-1:0] w_in_data;
    logic [1:0]   w_op, w_in_op;
    logic [wh_len_width_p-1:0] w_in_len;
    logic         w_in_rdy, w_out_v, w_cmd_v, w_wdata_v, w_rdata_rdy;
    logic [W-1:0] w_out_data, w_ret_hdr;
    logic         w_beat, w_last;

    assign w_in_v    = wh_link_sif_i[W+1];
    assign w_in_data = wh_link_sif_i[W:1];
    assign w_out_rdy = wh_link_sif_i[0];
    assign w_op      = r_hdr[OP_LSB +: 2];
    assign w_in_op   = w_in_data[OP_LSB +: 2];
    assign w_in_len  = w_in_data[LEN_LSB +: wh_len_width_p];
    assign w_last    = (r_cnt == LAST_BEAT);

    // Return header starts as a copy of the request so the unused bits echo back
    always_comb begin
        w_ret_hdr = r_hdr;
        w_ret_hdr[CORD_LSB  +: wh_cord_width_p] = r_hdr[SCORD_LSB +: wh_cord_width_p];
        w_ret_hdr[CID_LSB   +: wh_cid_width_p]  = r_hdr[SCID_LSB  +: wh_cid_width_p];
        w_ret_hdr[SCORD_LSB +: wh_cord_width_p] = my_wh_cord_i;
        w_ret_hdr[SCID_LSB  +: wh_cid_width_p]  = my_wh_cid_i;
        w_ret_hdr[LEN_LSB   +: wh_len_width_p]  = wh_len_width_p'(dma_burst_len_p);
        w_ret_hdr[OP_LSB    +: 2]               = 2'b00;
    end

    always_comb begin
        w_state_n   = r_state;
        w_in_rdy    = 1'b0;
        w_out_v     = 1'b0;
        w_out_data  = w_ret_hdr;
        w_cmd_v     = 1'b0;
        w_wdata_v   = 1'b0;
        w_rdata_rdy = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            S_RECV_HDR: begin
                w_in_rdy = 1'b1;
                if (w_in_v) w_state_n = S_RECV_ADDR;
            end
            S_RECV_ADDR: begin
                w_in_rdy = 1'b1;
                if (w_in_v) w_state_n = (w_op == 2'd2) ? S_RECV_MASK : S_CMD;
            end
            S_RECV_MASK: begin
                w_in_rdy = 1'b1;
                if (w_in_v) w_state_n = S_CMD;
            end
            S_CMD: begin
                w_cmd_v = 1'b1;
                if (mem.mem_cmd_ready_and_i)
                    w_state_n = (w_op != 2'd0) ? S_WDATA : S_RESP_HDR;
            end
            S_WDATA: begin
                w_in_rdy  = mem.mem_wdata_ready_and_i;
                w_wdata_v = w_in_v;
                w_beat    = w_in_v & mem.mem_wdata_ready_and_i;
                if (w_beat && w_last) w_state_n = S_RECV_HDR;
            end
            S_RESP_HDR: begin
                w_out_v = 1'b1;
                if (w_out_rdy) w_state_n = S_RESP_DATA;
            end
            S_RESP_DATA: begin
                w_out_v     = mem.mem_rdata_v_i;
                w_out_data  = mem.mem_rdata_i;
                w_rdata_rdy = w_out_rdy;
                w_beat      = mem.mem_rdata_v_i & w_out_rdy;
                if (w_beat && w_last) w_state_n = S_RECV_HDR;
            end
            default: w_state_n = S_RECV_HDR;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_RECV_HDR;
            r_hdr   <= '0;
            r_addr  <= '0;
            r_mask  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            if (r_state == S_RECV_HDR && w_in_v) r_hdr <= w_in_data;
            if (r_state == S_RECV_ADDR && w_in_v) begin
                r_addr <= w_in_data[dma_addr_width_p-1:0];
                if (w_op == 2'd0)      r_mask <= '0;
                else if (w_op != 2'd2) r_mask <= '1;
            end
            if (r_state == S_RECV_MASK && w_in_v) r_mask <= w_in_data[dma_mask_width_p-1:0];
            if (w_beat) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Protocol sanity on incoming headers; opcode 3 still flows as a plain write
    always_ff @(posedge clk_i) begin
        if (reset_n_i && r_state == S_RECV_HDR && w_in_v) begin
            assert (w_in_op != 2'd3)
                else $error("illegal wormhole DMA opcode 3");
            assert (w_in_len == ((w_in_op == 2'd0) ? wh_len_width_p'(1) :
                                 (w_in_op == 2'd2) ? wh_len_width_p'(dma_burst_len_p + 2) :
                                                     wh_len_width_p'(dma_burst_len_p + 1)))
                else $error("wormhole DMA header len does not match opcode");
        end
    end

    // All valids/readies are forced low while reset is held
    assign wh_link_sif_o = {w_out_v & reset_n_i, w_out_data, w_in_rdy & reset_n_i};

    assign mem.mem_cmd_v_o              = w_cmd_v & reset_n_i;
    assign mem.mem_cmd_write_not_read_o = (w_op != 2'd0);
    assign mem.mem_cmd_addr_o           = r_addr;
    assign mem.mem_cmd_mask_o           = r_mask;
    assign mem.mem_wdata_o              = w_in_data;
    assign mem.mem_wdata_v_o            = w_wdata_v & reset_n_i;
    assign mem.mem_rdata_ready_and_o    = w_rdata_rdy & reset_n_i;

    logic w_unused_ok;
    assign w_unused_ok = ^{w_in_data, w_in_len, w_in_op};
endmodule

// File: tb/tb_bsg_cache_wormhole_to_dma_mem.sv
// Scoreboard bench: expected commands, write beats and return flits are queued
// as stimulus is driven and checked when the DUT hands them off.
`timescale 1ns/1ps
module tb_bsg_cache_wormhole_to_dma_mem;
    localparam int AW = 28, MW = 8, W = 32, CORDW = 4, LENW = 4, CIDW = 2, BL = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [MW-1:0] mask;
    } cmd_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_v = 1'b0, out_rdy = 1'b1;
    logic [W-1:0] in_data = '0;
    logic [W+1:0] link_i, link_o;
    logic [CORDW-1:0] my_cord = 4'h9;
    logic [CIDW-1:0]  my_cid  = 2'h1;
    logic stall_en = 1'b0;

    int n_cmp = 0, n_err = 0;
    int wbeat = 0;
    logic chk_ret_hdr = 1'b0, chk_b2b = 1'b0;

    cmd_t         exp_cmd[$];
    logic [W-1:0] exp_wd[$], exp_out[$], rd_q[$];

    always #5 clk = ~clk;

    assign link_i = {in_v, in_data, out_rdy};

    bsg_cache_wormhole_to_dma_mem_if #(.addr_width_p(AW), .mask_width_p(MW), .data_width_p(W)) mem_if ();

    bsg_cache_wormhole_to_dma_mem #(
        .dma_addr_width_p(AW), .dma_burst_len_p(BL), .dma_mask_width_p(MW),
        .wh_flit_width_p(W), .wh_cord_width_p(CORDW), .wh_len_width_p(LENW),
        .wh_cid_width_p(CIDW)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .wh_link_sif_i(link_i), .wh_link_sif_o(link_o),
        .my_wh_cord_i(my_cord), .my_wh_cid_i(my_cid),
        .mem(mem_if.master)
    );

    wire          in_rdy   = link_o[0];
    wire          out_v    = link_o[W+1];
    wire [W-1:0]  out_data = link_o[W:1];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_hdr(input logic [13:0] unused, input logic [1:0] op,
                                            input logic [CIDW-1:0] scid, input logic [CORDW-1:0] scord,
                                            input logic [CIDW-1:0] cid, input logic [LENW-1:0] len,
                                            input logic [CORDW-1:0] cord);
        return {unused, op, scid, scord, cid, len, cord};
    endfunction

    // Memory side model and monitors: drive at negedge, observe handshakes at +3
    always @(negedge clk) begin
        mem_if.mem_cmd_ready_and_i   = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_if.mem_wdata_ready_and_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        out_rdy                      = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        mem_if.mem_rdata_v_i = (rd_q.size() != 0);
        mem_if.mem_rdata_i   = (rd_q.size() != 0) ? rd_q[0] : '0;
        #3;
        if (rst_n) begin
            if (chk_ret_hdr) begin
                chk("ret_hdr_latency", out_v, 1'b1);
                chk_ret_hdr = 1'b0;
            end
            if (chk_b2b) begin
                chk("b2b_hdr_ready", in_rdy, 1'b1);
                chk_b2b = 1'b0;
            end
            if (mem_if.mem_cmd_v_o) chk("cmd_holds_link", in_rdy, 1'b0);
            if (mem_if.mem_cmd_v_o && mem_if.mem_cmd_ready_and_i) begin
                if (exp_cmd.size() == 0) chk("cmd_unexpected", mem_if.mem_cmd_v_o, 1'b0);
                else begin
                    cmd_t e;
                    cmd_t g;
                    e = exp_cmd.pop_front();
                    g = '{we: mem_if.mem_cmd_write_not_read_o, addr: mem_if.mem_cmd_addr_o,
                          mask: mem_if.mem_cmd_mask_o};
                    chk("cmd", 64'(g), 64'(e));
                    if (!e.we) chk_ret_hdr = 1'b1;
                end
            end
            if (mem_if.mem_wdata_v_o && mem_if.mem_wdata_ready_and_i) begin
                if (exp_wd.size() == 0) chk("wdata_unexpected", mem_if.mem_wdata_v_o, 1'b0);
                else chk("wdata", mem_if.mem_wdata_o, exp_wd.pop_front());
                wbeat++;
                if (wbeat == BL) begin
                    wbeat   = 0;
                    chk_b2b = 1'b1;
                end
            end
            if (out_v && out_rdy) begin
                if (exp_out.size() == 0) chk("out_unexpected", out_v, 1'b0);
                else chk("out_flit", out_data, exp_out.pop_front());
            end
            if (mem_if.mem_rdata_v_i && mem_if.mem_rdata_ready_and_o) void'(rd_q.pop_front());
        end
    end

    task automatic send_flit(input logic [W-1:0] f);
        int n = 0;
        in_v = 1'b1;
        in_data = f;
        #1;
        while (!in_rdy && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 1000) chk("link_timeout", in_rdy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_v = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [CORDW-1:0] scord,
                           input logic [CIDW-1:0] scid, input logic [13:0] unused,
                           input logic [W-1:0] base);
        exp_cmd.push_back('{we: 1'b0, addr: addr, mask: '0});
        exp_out.push_back(mk_hdr(unused, 2'd0, my_cid, my_cord, scid, LENW'(BL), scord));
        for (int i = 0; i < BL; i++) begin
            exp_out.push_back(base + W'(i));
            rd_q.push_back(base + W'(i));
        end
        send_flit(mk_hdr(unused, 2'd0, scid, scord, 2'd0, 4'd1, 4'd0));
        send_flit(W'(addr));
    endtask

    task automatic do_write(input logic masked, input logic [AW-1:0] addr,
                            input logic [MW-1:0] mask, input logic [W-1:0] base);
        exp_cmd.push_back('{we: 1'b1, addr: addr, mask: masked ? mask : '1});
        for (int i = 0; i < BL; i++) exp_wd.push_back(base ^ W'(i * 32'h0101_0101));
        send_flit(mk_hdr(14'h0, masked ? 2'd2 : 2'd1, 2'd2, 4'd5, 2'd0,
                         masked ? LENW'(BL + 2) : LENW'(BL + 1), 4'd0));
        send_flit(W'(addr));
        if (masked) send_flit(W'(mask));
        for (int i = 0; i < BL; i++) send_flit(base ^ W'(i * 32'h0101_0101));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_cmd.size() + exp_wd.size() + exp_out.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_cmd.size() + exp_wd.size() + exp_out.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        in_v = 1'b1;
        in_data = '0;
        #12;
        chk("rst_in_rdy", in_rdy, 1'b0);
        chk("rst_out_v", out_v, 1'b0);
        chk("rst_cmd_v", mem_if.mem_cmd_v_o, 1'b0);
        chk("rst_wdata_v", mem_if.mem_wdata_v_o, 1'b0);
        chk("rst_rdata_rdy", mem_if.mem_rdata_ready_and_o, 1'b0);
        in_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_rdy", in_rdy, 1'b1);
        chk("post_rst_cmd_v", mem_if.mem_cmd_v_o, 1'b0);

        do_read(28'h1000, 4'd3, 2'd1, 14'd2, 32'hD000_0000);
        do_write(1'b0, 28'h2040, 8'h00, 32'hA0B0_C0D0);
        do_write(1'b1, 28'h3080, 8'h05, 32'h1234_5678);
        wait_drain();

        stall_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            do_write(1'b0, AW'($urandom) & 28'hFFF_FFC0, 8'h0, W'($urandom));
            do_read(AW'($urandom), CORDW'($urandom), CIDW'($urandom), 14'($urandom), W'($urandom));
            do_write(1'b1, AW'($urandom), MW'($urandom), W'($urandom));
        end
        wait_drain();
        stall_en = 1'b0;

        do_write(1'b0, 28'h0400, 8'h0, 32'hCAFE_0000);
        do_read(28'h0800, 4'd7, 2'd3, 14'h3FFF, 32'hBEEF_0000);
        wait_drain();

        // abandon a write mid-burst with an asynchronous reset
        exp_cmd.push_back('{we: 1'b1, addr: 28'h5000, mask: '1});
        send_flit(mk_hdr(14'h0, 2'd1, 2'd0, 4'd1, 2'd0, LENW'(BL + 1), 4'd0));
        send_flit(W'(28'h5000));
        exp_wd.push_back(32'h5555_0000);
        exp_wd.push_back(32'h5555_0001);
        send_flit(32'h5555_0000);
        send_flit(32'h5555_0001);
        in_v = 1'b1;
        in_data = 32'h5555_0002;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wdata_v", mem_if.mem_wdata_v_o, 1'b0);
        chk("async_rst_in_rdy", in_rdy, 1'b0);
        chk("async_rst_out_v", out_v, 1'b0);
        chk("async_rst_cmd_v", mem_if.mem_cmd_v_o, 1'b0);
        in_v = 1'b0;
        exp_wd.delete();
        wbeat = 0;
        chk_b2b = 1'b0;
        chk_ret_hdr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        do_read(28'h6000, 4'd2, 2'd2, 14'd9, 32'hF00D_0000);
        wait_drain();
        chk("rd_q_left", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
